// File: rtl/ahb_wrr_burst_arbiter.sv
// ahb_wrr_burst_arbiter
//
// Weighted round-robin arbiter that shares one AHB slave port among up to
// MASTER_NUM masters. A grant is held for a whole burst. Ownership moves only
// at a burst boundary, and a master may keep the port for up to weight[m]
// back-to-back transactions before the grant rotates.
//
// Ports
//   hclk      in   clock, rising edge
//   hreset_n  in   asynchronous active-low reset
//   hreq      in   [MASTER_NUM]              per-master request (level)
//   hburst    in   [MASTER_NUM*3]            per-master HBURST, master m at [3m +: 3]
//   hwait     in   slave wait; a beat is accepted when hsel=1 and hwait=0
//   weight    in   [MASTER_NUM*WEIGHT_BIT]   transactions per turn, 0 acts as 1
//   hgrant    out  [MASTER_NUM]              registered one-hot grant, 0 when idle
//   hmaster   out  [clog2(MASTER_NUM)]       current owner index, 0 when idle
//   hsel      out  OR of hgrant
//   hlast     out  current beat is the final beat of the current transaction

module ahb_wrr_burst_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int WEIGHT_BIT = 3,
    parameter int INCR_MAX   = 16,
    localparam int IDX_W     = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
    input  logic                             hclk,
    input  logic                             hreset_n,
    input  logic [MASTER_NUM-1:0]            hreq,
    input  logic [MASTER_NUM*3-1:0]          hburst,
    input  logic                             hwait,
    input  logic [MASTER_NUM*WEIGHT_BIT-1:0] weight,
    output logic [MASTER_NUM-1:0]            hgrant,
    output logic [IDX_W-1:0]                 hmaster,
    output logic                             hsel,
    output logic                             hlast
);

    // Beat counter must hold 15 (INCR16 countdown) and INCR_MAX-1 (INCR count-up).
    localparam int BEAT_W = (INCR_MAX > 16) ? $clog2(INCR_MAX) : 4;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t                fsm;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      ptr;
    logic [BEAT_W-1:0]     beats;
    logic [WEIGHT_BIT-1:0] served;
    logic                  undef;

    logic [2:0]            burst_a  [MASTER_NUM];
    logic [WEIGHT_BIT-1:0] weight_a [MASTER_NUM];

    for (genvar g = 0; g < MASTER_NUM; g++) begin : g_unpack
        assign burst_a[g]  = hburst[g*3 +: 3];
        assign weight_a[g] = weight[g*WEIGHT_BIT +: WEIGHT_BIT];
    end

    // Returns {found, index} of the first requester at or after start, wrapping.
    function automatic logic [IDX_W:0] pick(input logic [MASTER_NUM-1:0] req,
                                            input logic [IDX_W-1:0]      start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            k = IDX_W'((int'(start) + i) % MASTER_NUM);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    // Returns {undef, initial beats}: fixed bursts count down from len-1,
    // undefined-length INCR counts up from 0.
    function automatic logic [BEAT_W:0] decode_len(input logic [2:0] b);
        case (b)
            3'd0:       return {1'b0, BEAT_W'(0)};
            3'd1:       return {1'b1, BEAT_W'(0)};
            3'd2, 3'd3: return {1'b0, BEAT_W'(3)};
            3'd4, 3'd5: return {1'b0, BEAT_W'(7)};
            default:    return {1'b0, BEAT_W'(15)};
        endcase
    endfunction

    logic                  last_cond;
    logic                  accept;
    logic                  keep;
    logic [WEIGHT_BIT:0]   eff_w;
    logic [WEIGHT_BIT:0]   served_inc;
    logic [IDX_W-1:0]      nxt_ptr;
    logic [IDX_W-1:0]      search_start;
    logic [IDX_W:0]        pick_res;
    logic                  found;
    logic [IDX_W-1:0]      sel_idx;
    logic [BEAT_W:0]       load_dec;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        last_cond    = 1'b0;
        eff_w        = '0;
        served_inc   = '0;
        keep         = 1'b0;
        nxt_ptr      = '0;
        search_start = '0;
        pick_res     = '0;
        found        = 1'b0;
        sel_idx      = '0;
        load_dec     = '0;

        if (undef)
            last_cond = !hreq[owner] || (beats == BEAT_W'(INCR_MAX - 1));
        else
            last_cond = (beats == '0);

        eff_w      = (weight_a[owner] == '0) ? (WEIGHT_BIT+1)'(1) : {1'b0, weight_a[owner]};
        served_inc = {1'b0, served} + (WEIGHT_BIT+1)'(1);
        keep       = (served_inc < eff_w) && hreq[owner];

        // Searching from owner+1 over all requests reaches the old owner last,
        // so it wins again only when nobody else is requesting.
        nxt_ptr      = IDX_W'((int'(owner) + 1) % MASTER_NUM);
        search_start = (fsm == S_IDLE) ? ptr : nxt_ptr;
        pick_res     = pick(hreq, search_start);
        found        = pick_res[IDX_W];

        if (fsm == S_BURST && keep)
            sel_idx = owner;
        else
            sel_idx = pick_res[IDX_W-1:0];

        load_dec = decode_len(burst_a[sel_idx]);
    end

    assign accept = hsel & ~hwait;
    assign hsel   = |hgrant;
    assign hlast  = hsel & last_cond;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            fsm     <= S_IDLE;
            owner   <= '0;
            ptr     <= '0;
            beats   <= '0;
            served  <= '0;
            undef   <= 1'b0;
            hgrant  <= '0;
            hmaster <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (found) begin
                        fsm             <= S_BURST;
                        owner           <= sel_idx;
                        hmaster         <= sel_idx;
                        hgrant          <= MASTER_NUM'(1) << sel_idx;
                        served          <= '0;
                        {undef, beats}  <= load_dec;
                    end
                end

                S_BURST: begin
                    if (accept) begin
                        if (!last_cond) begin
                            beats <= undef ? beats + BEAT_W'(1) : beats - BEAT_W'(1);
                        end else if (keep) begin
                            // Same owner, next transaction of its turn, no bubble.
                            served         <= served_inc[WEIGHT_BIT-1:0];
                            {undef, beats} <= load_dec;
                        end else begin
                            ptr <= nxt_ptr;
                            if (found) begin
                                owner          <= sel_idx;
                                hmaster        <= sel_idx;
                                hgrant         <= MASTER_NUM'(1) << sel_idx;
                                served         <= '0;
                                {undef, beats} <= load_dec;
                            end else begin
                                fsm     <= S_IDLE;
                                owner   <= '0;
                                hmaster <= '0;
                                hgrant  <= '0;
                                served  <= '0;
                                beats   <= '0;
                                undef   <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_wrr_burst_arbiter.sv
// Self-checking bench for ahb_wrr_burst_arbiter: directed scenarios followed
// by randomized traffic, all compared against a transaction-level model.

module tb_ahb_wrr_burst_arbiter;

    localparam int N  = 4;
    localparam int WB = 3;
    localparam int IM = 16;

    logic              hclk;
    logic              hreset_n;
    logic [N-1:0]      hreq;
    logic [N*3-1:0]    hburst;
    logic              hwait;
    logic [N*WB-1:0]   weight;
    logic [N-1:0]      hgrant;
    logic [1:0]        hmaster;
    logic              hsel;
    logic              hlast;

    logic [2:0]        bur [N];
    logic [WB-1:0]     wt  [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign hburst[g*3 +: 3]   = bur[g];
        assign weight[g*WB +: WB] = wt[g];
    end

    ahb_wrr_burst_arbiter #(
        .MASTER_NUM (N),
        .WEIGHT_BIT (WB),
        .INCR_MAX   (IM)
    ) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .hreq     (hreq),
        .hburst   (hburst),
        .hwait    (hwait),
        .weight   (weight),
        .hgrant   (hgrant),
        .hmaster  (hmaster),
        .hsel     (hsel),
        .hlast    (hlast)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner = -1 when idle; len = 0 marks an undefined-length INCR;
    // done = beats accepted so far in this transaction; turns = transactions
    // completed in the current turn.
    int m_owner, m_len, m_done, m_turns, m_ptr;

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic int first_req(input int start, input logic [N-1:0] req);
        for (int i = 0; i < N; i++) begin
            if (req[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    function automatic bit m_final();
        if (m_owner < 0) return 1'b0;
        if (m_len != 0) return m_done == m_len - 1;
        return !hreq[m_owner] || (m_done == IM - 1);
    endfunction

    task automatic m_start(input int w);
        m_owner = w;
        m_len   = burst_len(bur[w]);
        m_done  = 0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_len   = 0;
        m_done  = 0;
        m_turns = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] cand;
        int           w;
        int           eff;
        if (m_owner < 0) begin
            w = first_req(m_ptr, hreq);
            if (w >= 0) begin
                m_start(w);
                m_turns = 0;
            end
        end else if (!hwait) begin
            if (!m_final()) begin
                m_done++;
            end else begin
                eff = (wt[m_owner] == 0) ? 1 : int'(wt[m_owner]);
                m_turns++;
                if (m_turns < eff && hreq[m_owner]) begin
                    m_start(m_owner);
                end else begin
                    m_ptr = (m_owner + 1) % N;
                    cand  = hreq;
                    cand[m_owner] = 1'b0;
                    if (cand == '0) cand = hreq;
                    w = first_req(m_ptr, cand);
                    if (w >= 0) begin
                        m_start(w);
                        m_turns = 0;
                    end else begin
                        m_owner = -1;
                    end
                end
            end
        end
    endtask

    // ---------------- cycle driver ----------------
    logic [N-1:0] o_grant;
    logic [1:0]   o_master;
    logic         o_last;

    // Called at a falling edge with this cycle's inputs already applied.
    task automatic tick();
        logic [31:0] eg;
        #1;
        o_grant  = hgrant;
        o_master = hmaster;
        o_last   = hlast;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("hgrant",  32'(hgrant),  eg);
        check("hmaster", 32'(hmaster), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("hsel",    32'(hsel),    (m_owner >= 0) ? 32'd1 : 32'd0);
        check("hlast",   32'(hlast),   32'(m_final()));
        model_step();
        @(negedge hclk);
    endtask

    task automatic clear_inputs();
        hreq  = '0;
        hwait = 1'b0;
        for (int i = 0; i < N; i++) begin
            bur[i] = 3'd0;
            wt[i]  = '0;
        end
    endtask

    task automatic do_reset();
        hreset_n = 1'b0;
        #1;
        check("rst_hgrant",  32'(hgrant),  32'd0);
        check("rst_hmaster", 32'(hmaster), 32'd0);
        check("rst_hsel",    32'(hsel),    32'd0);
        check("rst_hlast",   32'(hlast),   32'd0);
        model_reset();
        clear_inputs();
        @(negedge hclk);
        hreset_n = 1'b1;
    endtask

    int gcnt, lcnt, lastc;

    initial begin
        hreset_n = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        do_reset();

        // Single INCR4 request, dropped once granted.
        bur[0] = 3'd3;
        for (int c = 0; c < 7; c++) begin
            hreq = (c == 0) ? 4'b0001 : 4'b0000;
            tick();
            check("incr4_grant", 32'(o_grant), (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            check("incr4_last",  32'(o_last),  (c == 4) ? 32'd1 : 32'd0);
        end

        // Round-robin fairness: all SINGLE, weights 0.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            hreq = 4'b1111;
            tick();
            if (c >= 1) begin
                check("rr_master", 32'(o_master), 32'((c - 1) % 4));
                check("rr_last",   32'(o_last),   32'd1);
            end
        end

        // Weighting: master 1 gets three transactions per turn, master 2 one.
        do_reset();
        wt[1] = 3'd3;
        wt[2] = 3'd0;
        for (int c = 0; c < 9; c++) begin
            hreq = 4'b0110;
            tick();
            if (c >= 1)
                check("wrr_master", 32'(o_master), ((c - 1) % 4 == 3) ? 32'd2 : 32'd1);
        end

        // WRAP8 with two 2-cycle stalls on beats 2 and 5.
        do_reset();
        bur[0] = 3'd4;
        gcnt = 0; lcnt = 0; lastc = -1;
        for (int c = 0; c < 15; c++) begin
            hreq  = (c == 0) ? 4'b0001 : 4'b0000;
            hwait = (c == 2 || c == 3 || c == 7 || c == 8);
            tick();
            if (o_grant == 4'b0001) gcnt++;
            if (o_last) begin
                lcnt++;
                lastc = c;
            end
        end
        check("wait_hold",     32'(gcnt),  32'd12);
        check("wait_last_cnt", 32'(lcnt),  32'd1);
        check("wait_last_at",  32'(lastc), 32'd12);

        // Undefined INCR on master 3, request dropped after 5 accepted beats.
        do_reset();
        bur[3] = 3'd1;
        bur[1] = 3'd0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0)      hreq = 4'b1000;
            else if (c <= 5) hreq = 4'b1010;
            else if (c <= 7) hreq = 4'b0010;
            else             hreq = 4'b0000;
            tick();
            if (c >= 1 && c <= 6) check("undef_master", 32'(o_master), 32'd3);
            if (c >= 1 && c <= 6) check("undef_last", 32'(o_last), (c == 6) ? 32'd1 : 32'd0);
            if (c == 7)           check("undef_handover", 32'(o_grant), 32'b0010);
        end

        // Undefined INCR held: forced end at INCR_MAX beats.
        do_reset();
        bur[3] = 3'd1;
        for (int c = 0; c < 18; c++) begin
            hreq = 4'b1000;
            tick();
            check("cap_grant", 32'(o_grant), (c >= 1) ? 32'b1000 : 32'd0);
            check("cap_last",  32'(o_last),  (c == 16) ? 32'd1 : 32'd0);
        end

        // Reset during beat 3 of INCR8, then restart with hreq=1010.
        do_reset();
        bur[0] = 3'd5;
        for (int c = 0; c < 3; c++) begin
            hreq = 4'b0001;
            tick();
        end
        #1;
        check("mid_pre_grant", 32'(hgrant), 32'b0001);
        hreset_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(hgrant), 32'd0);
        check("mid_rst_sel",   32'(hsel),   32'd0);
        check("mid_rst_last",  32'(hlast),  32'd0);
        model_reset();
        clear_inputs();
        hreq = 4'b1010;
        @(negedge hclk);
        hreset_n = 1'b1;
        tick();
        tick();
        check("post_rst_master", 32'(o_master), 32'd1);
        check("post_rst_grant",  32'(o_grant),  32'b0010);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < N; i++) wt[i] = WB'($urandom_range(0, 7));
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                for (int i = 0; i < N; i++) wt[i] = WB'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 199) == 0)
                for (int i = 0; i < N; i++) wt[i] = WB'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if ((c / 1000) % 2 == 0) hreq[i] = ($urandom_range(0, 3) != 0);
                else                     hreq[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) bur[i] = 3'($urandom_range(0, 7));
            end
            hwait = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_wrr_burst_arbiter.md
# ahb_wrr_burst_arbiter

Weighted round-robin arbiter that shares one AHB slave port among up to MASTER_NUM requesting masters. It tracks each granted burst beat by beat so that ownership changes only at a burst boundary. It also lets a master keep the port for up to its configured number of consecutive transactions before the grant rotates. It sits on the slave side of the interconnect, next to the per-slave fixed and round-robin arbiters, and drives the slave-select and master-index muxes.

## Interface
- MASTER_NUM, 4: number of requesting masters (2..8).
- WEIGHT_BIT, 3: width of each per-master weight field.
- INCR_MAX, 16: beat cap for undefined-length INCR bursts (1..256).
- hclk  in  1  clock; all state updates on the rising edge.
- hreset_n  in  1  asynchronous, active-low reset.
- hreq  in  MASTER_NUM  per-master request, level-sensitive.
- hburst  in  MASTER_NUM x 3  per-master HBURST: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- hwait  in  1  slave wait (HREADY low); a beat is accepted in a cycle with hsel=1 and hwait=0.
- weight  in  MASTER_NUM x WEIGHT_BIT  quasi-static; number of consecutive transactions per turn. A value of 0 is treated as 1.
- hgrant  out  MASTER_NUM  registered one-hot grant; all zero when idle.
- hmaster  out  clog2(MASTER_NUM)  index of the current owner; 0 when idle.
- hsel  out  1  OR of hgrant.
- hlast  out  1  high while the current beat is the final beat of the current transaction.

## Operation
- State registers: fsm (IDLE, BURST), owner index, rr pointer ptr, beat counter beats, served counter served, and an undefined-length flag undef.
- Winner selection: the first requester found searching ptr, ptr+1, … modulo MASTER_NUM.
- Length decode from hburst[winner], sampled at the grant-load edge:
  - SINGLE: 1 beat.
  - WRAP4/INCR4: 4 beats.
  - WRAP8/INCR8: 8 beats.
  - WRAP16/INCR16: 16 beats.
  - INCR: undef=1.
- Loading a grant sets beats=len-1, served=0, hgrant=onehot(winner).
- IDLE:
  - If any hreq is set, load a grant to the winner and go to BURST.
  - Otherwise stay in IDLE with outputs zero.
- BURST, fixed-length transaction:
  - Each accepted beat decrements beats.
  - The last beat is the one where beats==0.
- BURST, undefined-length INCR:
  - beats counts up from 0.
  - The last beat is an accepted beat with hreq[owner]=0 or beats==INCR_MAX-1.
- hlast = hsel & last-beat condition. It is combinational from registers and hreq[owner], and does not depend on hwait.
- When the last beat is accepted (end of transaction):
  - served+1 < max(weight[owner],1) and hreq[owner]=1: the same owner continues, with served+1 and a new length from hburst[owner]. There is no bubble cycle.
  - Otherwise: ptr = owner+1 mod MASTER_NUM. Search again from the new ptr, excluding the old owner unless it is the only requester.
    - If there is a winner, load its grant on the same edge (back-to-back, no idle cycle).
    - If there is none, go to IDLE. ptr keeps its updated value.
- hreq[owner] dropping during a fixed-length burst is ignored; the burst completes.
- Beats stalled by hwait: the counter holds and the grant holds.
- Changes to weight take effect at the next end-of-transaction evaluation.

## Timing
- Request-to-grant latency is 1 cycle. hreq sampled high in IDLE at edge N gives hgrant valid after edge N.
- A fixed burst of L beats holds hgrant for exactly L + (hwait stall cycles) cycles.
- Ownership change takes 0 idle cycles. The new hgrant is valid in the cycle after the old owner's last accepted beat.
- Reset values: hgrant=0, hmaster=0, hsel=0, hlast=0, ptr=0, fsm=IDLE, beats=0, served=0, undef=0.
- Reset asserted mid-burst: all outputs clear asynchronously. After release, arbitration restarts from ptr=0.
- hgrant is always one-hot or zero; hmaster==owner whenever hsel=1.

## Test plan
- Single request: hreq=0001, hburst[0]=INCR4, hwait=0.
  - Required: hgrant=0001 for 4 cycles starting one cycle after the request, and hlast in cycle 4.
  - If hreq then drops: IDLE, outputs 0.
- Round-robin fairness: all weights=0, all 4 masters request SINGLE continuously.
  - Required: hmaster sequence 0,1,2,3,0,… with one grant per cycle and hlast=1 every cycle.
- Weighting: weight[1]=3, weight[2]=0, hreq=0110, all SINGLE.
  - Required: hmaster pattern 1,1,1,2,1,1,1,2…
- Wait states: owner 0 with WRAP8 and hwait high on beats 2 and 5 for 2 cycles each.
  - Required: grant held 12 cycles; hlast high only in the final 1 cycle; no handover before that.
- Undefined INCR:
  - hreq[3] drops after 5 accepted beats: hlast on beat 6, then handover to the next requester.
  - hreq[3] held high: forced end after 16 beats with INCR_MAX=16.
- Reset mid-burst: hreset_n low during beat 3 of INCR8.
  - Required: outputs 0 immediately.
  - After release with hreq=1010: master 1 is granted first, because ptr=0.
